// File: rtl/dpm_writeback.sv
// dpm_writeback: requantizes 4x4 output groups, packs each group row into a word,
// and writes the words through a valid/ready port from a two-bank ping-pong buffer.
module dpm_writeback #(
    parameter int DATA_W     = 16,
    parameter int OUT_W      = 8,
    parameter int GROUP_ROWS = 4,
    parameter int ADDR_W     = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [11:0]                 num_groups,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [3:0]                  shift,
    input  logic [DATA_W-1:0]           pix_in,
    input  logic                        pix_in_valid,
    output logic [GROUP_ROWS*OUT_W-1:0] wr_data,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        overflow
);

    localparam int ROW_W  = $clog2(GROUP_ROWS);
    localparam int PIX_W  = 2 * ROW_W;
    localparam int WORD_W = GROUP_ROWS * OUT_W;

    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(GROUP_ROWS * GROUP_ROWS - 1);
    localparam logic [ROW_W-1:0] WORD_LAST = ROW_W'(GROUP_ROWS - 1);
    localparam logic signed [DATA_W:0] ONE_S = (DATA_W+1)'(1);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    // Frame configuration, latched at start
    logic [11:0]       num_groups_q;
    logic [ADDR_W-1:0] base_q;
    logic [3:0]        shift_q;

    // Ping-pong storage: [bank][row][col]
    logic [GROUP_ROWS-1:0][OUT_W-1:0] bank_q [2][GROUP_ROWS];
    logic [1:0]        full_q;

    // Fill side
    logic              fill_ptr_q;
    logic [PIX_W-1:0]  pix_idx_q;

    // Drain side
    state_t            state_q;
    logic              drain_ptr_q;
    logic [ROW_W-1:0]  word_q;
    logic [11:0]       group_q;
    logic [ADDR_W-1:0] nxt_addr_q;

    // Registered outputs
    logic [WORD_W-1:0] wr_data_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              wr_valid_q;
    logic              busy_q;
    logic              frame_done_q;
    logic              overflow_q;

    // Combinational helpers
    logic signed [DATA_W:0] ext_s;
    logic signed [DATA_W:0] rnd_s;
    logic signed [DATA_W:0] sum_s;
    logic signed [DATA_W:0] res_s;
    logic [OUT_W-1:0]       pix_req;
    logic                   pix_we;
    logic [ROW_W-1:0]       word_nx;
    logic [ADDR_W-1:0]      addr_inc;
    logic [11:0]            group_inc;

    assign wr_data    = wr_data_q;
    assign wr_addr    = wr_addr_q;
    assign wr_valid   = wr_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

    assign pix_we    = busy_q && pix_in_valid && !full_q[fill_ptr_q];
    assign word_nx   = word_q + ROW_W'(1);
    assign addr_inc  = nxt_addr_q + ADDR_W'(1);
    assign group_inc = group_q + 12'd1;

    // Round-half-up right shift in DATA_W+1 bits, then clamp to unsigned OUT_W
    always_comb begin
        ext_s = {pix_in[DATA_W-1], pix_in};
        rnd_s = '0;
        if (shift_q != 4'd0) begin
            rnd_s = ONE_S << (shift_q - 4'd1);
        end
        sum_s = ext_s + rnd_s;
        res_s = sum_s >>> shift_q;
        if (res_s[DATA_W]) begin
            pix_req = '0;
        end else if (|res_s[DATA_W-1:OUT_W]) begin
            pix_req = '1;
        end else begin
            pix_req = res_s[OUT_W-1:0];
        end
    end

    // Pixel storage into the fill bank; contents need no reset
    always_ff @(posedge clk) begin
        if (pix_we) begin
            bank_q[fill_ptr_q][pix_idx_q[PIX_W-1:ROW_W]][pix_idx_q[ROW_W-1:0]] <= pix_req;
        end
    end

    // Frame control, fill bookkeeping and drain FSM with registered outputs
    always_ff @(posedge clk) begin
        frame_done_q <= 1'b0;
        if (rst) begin
            num_groups_q <= '0;
            base_q       <= '0;
            shift_q      <= '0;
            full_q       <= '0;
            fill_ptr_q   <= 1'b0;
            pix_idx_q    <= '0;
            state_q      <= S_IDLE;
            drain_ptr_q  <= 1'b0;
            word_q       <= '0;
            group_q      <= '0;
            nxt_addr_q   <= '0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
            wr_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else if (start && !busy_q) begin
            num_groups_q <= num_groups;
            base_q       <= base_addr;
            shift_q      <= shift;
            full_q       <= '0;
            fill_ptr_q   <= 1'b0;
            pix_idx_q    <= '0;
            state_q      <= S_IDLE;
            drain_ptr_q  <= 1'b0;
            word_q       <= '0;
            group_q      <= '0;
            nxt_addr_q   <= base_addr;
            wr_valid_q   <= 1'b0;
            busy_q       <= 1'b1;
            overflow_q   <= 1'b0;
        end else if (busy_q) begin
            // Fill side: a full target bank drops the pixel
            if (pix_in_valid) begin
                if (full_q[fill_ptr_q]) begin
                    overflow_q <= 1'b1;
                end else begin
                    pix_idx_q <= pix_idx_q + PIX_W'(1);
                    if (pix_idx_q == PIX_LAST) begin
                        full_q[fill_ptr_q] <= 1'b1;
                        fill_ptr_q         <= ~fill_ptr_q;
                    end
                end
            end

            // Drain side
            unique case (state_q)
                S_IDLE: begin
                    if (full_q[drain_ptr_q]) begin
                        state_q    <= S_SEND;
                        word_q     <= '0;
                        wr_valid_q <= 1'b1;
                        wr_data_q  <= bank_q[drain_ptr_q][0];
                        wr_addr_q  <= nxt_addr_q;
                    end
                end
                S_SEND: begin
                    if (wr_ready) begin
                        nxt_addr_q <= addr_inc;
                        if (word_q != WORD_LAST) begin
                            word_q    <= word_nx;
                            wr_data_q <= bank_q[drain_ptr_q][word_nx];
                            wr_addr_q <= addr_inc;
                        end else begin
                            full_q[drain_ptr_q] <= 1'b0;
                            drain_ptr_q         <= ~drain_ptr_q;
                            group_q             <= group_inc;
                            word_q              <= '0;
                            if (group_inc == num_groups_q) begin
                                frame_done_q <= 1'b1;
                                busy_q       <= 1'b0;
                                wr_valid_q   <= 1'b0;
                                state_q      <= S_IDLE;
                            end else if (full_q[~drain_ptr_q]) begin
                                wr_data_q <= bank_q[~drain_ptr_q][0];
                                wr_addr_q <= addr_inc;
                            end else begin
                                wr_valid_q <= 1'b0;
                                state_q    <= S_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpm_writeback.sv
// Directed testbench for dpm_writeback: latency, packing, requant/clamp,
// backpressure, overflow, reset/restart and start-while-busy.
module tb_dpm_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] num_groups;
    logic [19:0] base_addr;
    logic [3:0]  shift;
    logic [15:0] pix_in;
    logic        pix_in_valid;
    logic [31:0] wr_data;
    logic [19:0] wr_addr;
    logic        wr_valid;
    logic        wr_ready;
    logic        busy;
    logic        frame_done;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dpm_writeback dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_groups   (num_groups),
        .base_addr    (base_addr),
        .shift        (shift),
        .pix_in       (pix_in),
        .pix_in_valid (pix_in_valid),
        .wr_data      (wr_data),
        .wr_addr      (wr_addr),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .busy         (busy),
        .frame_done   (frame_done),
        .overflow     (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wexp(input int first);
        return {8'(first + 3), 8'(first + 2), 8'(first + 1), 8'(first)};
    endfunction

    task automatic send_pix(input logic [15:0] v);
        pix_in       = v;
        pix_in_valid = 1'b1;
        tick();
        pix_in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [11:0] ng, input logic [19:0] ba, input logic [3:0] sh);
        num_groups = ng;
        base_addr  = ba;
        shift      = sh;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Wait (bounded) for a word, check it, then pass the handshake edge
    task automatic recv(input string tag, input logic [19:0] a, input logic [31:0] d,
                        input int max_wait);
        int waited = 0;
        while (wr_valid !== 1'b1 && waited < max_wait) begin
            tick();
            waited++;
        end
        chk({tag, "_valid"}, wr_valid, 1);
        chk({tag, "_addr"}, wr_addr, a);
        chk({tag, "_data"}, wr_data, d);
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_valid"}, wr_valid, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        num_groups   = '0;
        base_addr    = '0;
        shift        = '0;
        pix_in       = '0;
        pix_in_valid = 1'b0;
        wr_ready     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_all_zero("reset");

        // Single group, ready high, pixel value p*10
        wr_ready = 1'b1;
        do_start(12'd1, 20'h100, 4'd0);
        chk("t1_busy", busy, 1);
        for (int p = 0; p < 16; p++) send_pix(16'(p * 10));
        chk("t1_lat0", wr_valid, 0);
        tick();
        chk("t1_lat1", wr_valid, 1);
        recv("t1_w0", 20'h100, 32'h1E140A00, 0);
        recv("t1_w1", 20'h101, 32'h463C3228, 0);
        recv("t1_w2", 20'h102, 32'h6E645A50, 0);
        chk("t1_no_done_early", frame_done, 0);
        recv("t1_w3", 20'h103, 32'h968C8278, 0);
        chk("t1_done", frame_done, 1);
        chk("t1_busy_low", busy, 0);
        chk("t1_valid_low", wr_valid, 0);
        tick();
        chk("t1_done_pulse", frame_done, 0);

        // Requant, rounding and clamp with shift=2
        do_start(12'd1, 20'h110, 4'd2);
        send_pix(16'hFFFB);
        send_pix(16'd6);
        send_pix(16'd1023);
        send_pix(16'd2);
        send_pix(16'h7FFF);
        send_pix(16'h8000);
        send_pix(16'd9);
        send_pix(16'd10);
        for (int p = 0; p < 8; p++) send_pix(16'd0);
        recv("t2_w0", 20'h110, 32'h01FF0200, 5);
        recv("t2_w1", 20'h111, 32'h030200FF, 0);
        recv("t2_w2", 20'h112, 32'h0, 0);
        recv("t2_w3", 20'h113, 32'h0, 0);
        chk("t2_done", frame_done, 1);

        // Backpressure: two groups stream while the sink stalls
        wr_ready = 1'b0;
        do_start(12'd2, 20'h200, 4'd0);
        for (int k = 0; k < 32; k++) send_pix(16'(k));
        chk("t3_ovf_clear", overflow, 0);
        chk("t3_valid", wr_valid, 1);
        chk("t3_addr0", wr_addr, 20'h200);
        chk("t3_data0", wr_data, wexp(0));
        repeat (10) tick();
        chk("t3_hold_addr", wr_addr, 20'h200);
        chk("t3_hold_data", wr_data, wexp(0));
        wr_ready = 1'b1;
        for (int j = 0; j < 8; j++)
            recv($sformatf("t3_w%0d", j), 20'h200 + 20'(j), wexp(4 * j), 0);
        chk("t3_done", frame_done, 1);
        chk("t3_ovf_end", overflow, 0);

        // Overflow: third group arrives with both banks full
        wr_ready = 1'b0;
        do_start(12'd3, 20'h300, 4'd0);
        for (int k = 0; k < 32; k++) send_pix(16'(k));
        chk("t4_ovf_before", overflow, 0);
        send_pix(16'd32);
        chk("t4_ovf_set", overflow, 1);
        for (int k = 33; k < 48; k++) send_pix(16'(k));
        wr_ready = 1'b1;
        for (int j = 0; j < 8; j++)
            recv($sformatf("t4_w%0d", j), 20'h300 + 20'(j), wexp(4 * j), 0);
        repeat (5) tick();
        chk("t4_no_grp2", wr_valid, 0);
        chk("t4_still_busy", busy, 1);
        chk("t4_no_done", frame_done, 0);
        chk("t4_ovf_sticky", overflow, 1);

        // Reset mid-group, then a fresh frame
        for (int p = 0; p < 5; p++) send_pix(16'd77);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("t5_reset");
        do_start(12'd1, 20'h400, 4'd0);
        for (int p = 0; p < 16; p++) send_pix(16'(100 + p));
        recv("t5_w0", 20'h400, wexp(100), 5);
        recv("t5_w1", 20'h401, wexp(104), 0);
        recv("t5_w2", 20'h402, wexp(108), 0);
        recv("t5_w3", 20'h403, wexp(112), 0);
        chk("t5_done", frame_done, 1);

        // Start pulses during a frame are ignored
        do_start(12'd2, 20'h500, 4'd0);
        for (int p = 0; p < 16; p++) begin
            if (p == 3 || p == 9) begin
                start      = 1'b1;
                num_groups = 12'd1;
                base_addr  = 20'h700;
            end
            send_pix(16'(p));
            start = 1'b0;
        end
        for (int w = 0; w < 4; w++)
            recv($sformatf("t6_g0w%0d", w), 20'h500 + 20'(w), wexp(4 * w), (w == 0) ? 5 : 0);
        chk("t6_no_done", frame_done, 0);
        chk("t6_busy", busy, 1);
        for (int p = 16; p < 32; p++) begin
            if (p == 20) start = 1'b1;
            send_pix(16'(p));
            start = 1'b0;
        end
        for (int w = 0; w < 4; w++)
            recv($sformatf("t6_g1w%0d", w), 20'h504 + 20'(w), wexp(16 + 4 * w), (w == 0) ? 5 : 0);
        chk("t6_done", frame_done, 1);
        chk("t6_busy_low", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
